div4_restoring: RTL
===================

# div4_restoring

Sequential 4-bit unsigned restoring divider that sits directly downstream of the existing 4-bit subtractor `subt` and consumes its `D`/`Bout` outputs as the trial-subtraction result. The block sequences one shift/subtract/restore step per clock and delivers quotient and remainder through a start/done handshake. It is the first multi-cycle arithmetic block in the Exer1 datapath.

## Interface
- Parameters: none; datapath width is fixed at 4 bits to match `subt`.
- `Clk`  in  1  rising-edge clock
- `Rst`  in  1  synchronous, active-high reset
- `Start`  in  1  request; sampled only in IDLE
- `Dividend`  in  4  unsigned dividend, captured on accepted Start
- `Divisor`  in  4  unsigned divisor, captured on accepted Start
- `Busy`  out  1  high while iterating (RUN)
- `Done`  out  1  one-cycle pulse; results valid
- `Quotient`  out  4  registered quotient, held until next accepted Start
- `Remainder`  out  4  registered remainder, held until next accepted Start
- `DivZero`  out  1  registered; set when the captured Divisor was 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on `Start`=1, capture M=Divisor, Q=Dividend, R=0, count=0, and clear `DivZero`.
  - If Divisor=0, go to DONE with Quotient=4'hF, Remainder=Dividend, DivZero=1.
  - Otherwise go to RUN.
- RUN, one iteration per cycle:
  - {Rs,Qs} = {R,Q} << 1.
  - `subt` computes D = Rs − M and Bout.
  - If Bout=0: R=D and Q=Qs|1. Else R=Rs and Q=Qs (restore).
  - count increments. After the 4th iteration, go to DONE.
- DONE: Quotient=Q, Remainder=R, Done=1 for exactly one cycle, then IDLE.
- Width rule: R is always less than 16 because R never exceeds the dividend prefix. A 4-bit Rs is therefore exact, and no 5th trial bit exists.
- `Start` in RUN or DONE is ignored; it is not queued.
- Operand inputs are don't-care except in the cycle Start is accepted.
- Invariant at Done: Dividend = Quotient·Divisor + Remainder, and Remainder < Divisor (Divisor ≠ 0).

## Timing
- Reset values: state=IDLE; Busy, Done, DivZero, Quotient, Remainder, and internal R/Q/M/count all 0.
- `Rst` has priority over all other inputs in every state.
  - Reset mid-RUN aborts the operation, and no Done is produced.
  - Outputs return to 0 on the next edge.
- Start accepted at edge 0.
- Normal divide: Busy=1 after edges 0–3 (4 cycles). Edge 4 enters DONE, so Done=1 in the cycle after edge 4. Back to IDLE after edge 5. Start-to-Done latency is 5 cycles.
- Divide-by-zero: Done=1 in the cycle after edge 0, and Busy never asserts. Latency is 1 cycle.
- Earliest next Start acceptance is at the edge that leaves DONE +1, i.e. in IDLE. Back-to-back throughput is one result per 6 cycles.
- Quotient/Remainder/DivZero change only on DONE entry, on accepted Start (DivZero clears), or on reset.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the width constant 4, and the divide-by-zero quotient 4'hF.
- One sub-module: instantiate the existing `subt` (ports D, Bout, A=Rs, B=M) as the trial subtractor.
- FSM, counter and R/Q/M registers stay in `div4_restoring`.

## Test plan
- 13 ÷ 3, Start at edge 0 → Busy for 4 cycles; Done pulse at cycle 5 with Quotient=4, Remainder=1, DivZero=0.
- 15 ÷ 1 → Quotient=15, Remainder=0. Then 3 ÷ 7 → Quotient=0, Remainder=3. Then 15 ÷ 15 → Quotient=1, Remainder=0.
- 9 ÷ 0 → Done one cycle after Start; Quotient=4'hF, Remainder=9, DivZero=1, Busy never high.
- Start 14 ÷ 4, then pulse Start with 8 ÷ 2 during RUN → second request ignored; Done once with Quotient=3, Remainder=2; then a fresh Start in IDLE gives Quotient=4, Remainder=0.
- Start 11 ÷ 2, assert Rst in the 2nd RUN cycle → no Done pulse; all outputs 0; a following 11 ÷ 2 yields Quotient=5, Remainder=1.
- Exhaustive sweep of all 256 operand pairs → every Done satisfies the invariant, or the divide-by-zero values when Divisor=0.

Source files
------------

// File: rtl/div4_restoring_pkg.sv
// Shared constants for the 4-bit restoring divider: datapath width,
// divide-by-zero quotient and FSM state encoding.
package div4_restoring_pkg;

  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div4_restoring_subt.sv
// 4-bit subtractor: D = A - B, with Bout set when A < B (a borrow out of the MSB).
module subt
  import div4_restoring_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  assign {Bout, D} = {1'b0, A} - {1'b0, B};

endmodule

// File: rtl/div4_restoring.sv
// Sequential 4-bit unsigned restoring divider: one shift/subtract/restore step
// per clock, with a start/done handshake and a divide-by-zero flag.
//
// Handshake: Start is sampled only in IDLE; a Start seen in RUN or DONE is
// dropped. Done is high for exactly one cycle. Quotient, Remainder and DivZero
// are valid from that cycle and are held until the next accepted Start.
module div4_restoring
  import div4_restoring_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic [1:0]       state_dbg
);

  state_t           state, state_n;
  logic [WIDTH-1:0] r_reg, r_n;
  logic [WIDTH-1:0] q_reg, q_n;
  logic [WIDTH-1:0] m_reg, m_n;
  logic [1:0]       count, count_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic             divzero_n;

  logic [WIDTH-1:0] rs, qs, diff;
  logic             borrow;
  logic [WIDTH-1:0] trial_r, trial_q;

  // R never exceeds the dividend prefix consumed so far, so a 4-bit Rs is exact.
  assign rs = (r_reg << 1) | {{(WIDTH-1){1'b0}}, q_reg[WIDTH-1]};
  assign qs = q_reg << 1;

  subt u_subt (
    .A    (rs),
    .B    (m_reg),
    .D    (diff),
    .Bout (borrow)
  );

  assign trial_r = borrow ? rs : diff;
  assign trial_q = borrow ? qs : (qs | {{(WIDTH-1){1'b0}}, 1'b1});

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
    end else begin
      state     <= state_n;
      r_reg     <= r_n;
      q_reg     <= q_n;
      m_reg     <= m_n;
      count     <= count_n;
      Quotient  <= quotient_n;
      Remainder <= remainder_n;
      DivZero   <= divzero_n;
    end
  end

  always_comb begin
    state_n     = state;
    r_n         = r_reg;
    q_n         = q_reg;
    m_n         = m_reg;
    count_n     = count;
    quotient_n  = Quotient;
    remainder_n = Remainder;
    divzero_n   = DivZero;
    case (state)
      IDLE: begin
        if (Start) begin
          m_n       = Divisor;
          q_n       = Dividend;
          r_n       = '0;
          count_n   = '0;
          divzero_n = 1'b0;
          if (Divisor == '0) begin
            state_n     = DONE;
            quotient_n  = DIV_ZERO_QUOTIENT;
            remainder_n = Dividend;
            divzero_n   = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        r_n     = trial_r;
        q_n     = trial_q;
        count_n = count + 2'd1;
        // The fourth iteration publishes its own result directly.
        if (count == 2'd3) begin
          state_n     = DONE;
          quotient_n  = trial_q;
          remainder_n = trial_r;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign state_dbg = state;

endmodule
